// File: rtl/lut_neuron_layer.sv
// lut_neuron_layer: a layer of runtime-loadable truth-table neurons.
// Each neuron looks up an IN_BITS address in its own OUT_BITS-wide table.
// Tables are streamed in over the cfg port in this order: neuron 0 addresses
// 0..DEPTH-1, then neuron 1, and so on. Inference is a single registered
// stage with valid/ready handshakes on both sides.
//
// state | meaning
// ------+----------------------------------------------------------------
// EMPTY | no usable image; waiting for the first beat of a load
// LOAD  | load in progress; inference blocked
// RUN   | complete image present; inference enabled, reload allowed when drained
module lut_neuron_layer #(
  parameter int NUM_NEURONS = 4,
  parameter int IN_BITS     = 7,
  parameter int OUT_BITS    = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [OUT_BITS-1:0]             cfg_data,
  input  logic                            cfg_last,
  output logic                            cfg_err,
  output logic                            loaded,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_NEURONS*IN_BITS-1:0]  in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data
);

  localparam int DEPTH = 1 << IN_BITS;
  localparam int NW    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [NW-1:0] LAST_NRN = NW'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

  state_t               state_q, state_d;
  logic [IN_BITS-1:0]   addr_q, addr_d;
  logic [NW-1:0]        nrn_q, nrn_d;
  logic                 err_q, err_d;
  logic                 cfg_fire, in_fire, last_beat;

  // Table storage is deliberately not reset so it maps onto LUT RAM.
  logic [OUT_BITS-1:0]             mem [NUM_NEURONS][DEPTH];
  logic [NUM_NEURONS*OUT_BITS-1:0] lut_rd;

  assign cfg_fire  = cfg_valid && cfg_ready;
  assign in_fire   = in_valid && in_ready;
  assign last_beat = (nrn_q == LAST_NRN) && (&addr_q);

  // Synchronous table write at the current load position.
  always_ff @(posedge clk) begin
    if (cfg_fire) begin
      mem[nrn_q][addr_q] <= cfg_data;
    end
  end

  // Asynchronous per-neuron lookup; the result is registered into out_data.
  for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_rd
    assign lut_rd[i*OUT_BITS +: OUT_BITS] = mem[i][in_data[i*IN_BITS +: IN_BITS]];
  end

  // State, load counters and sticky error register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      addr_q  <= '0;
      nrn_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      nrn_q   <= nrn_d;
      err_q   <= err_d;
    end
  end

  // Next-state, counter advance, framing checks and handshake outputs.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    nrn_d     = nrn_q;
    err_d     = err_q;
    loaded    = 1'b0;
    in_ready  = 1'b0;
    cfg_ready = 1'b1;

    if (state_q == RUN) begin
      loaded    = 1'b1;
      in_ready  = !out_valid || out_ready;
      // A reload may only start once the output stage is empty and no input
      // is waiting, so an input always wins over a config beat.
      cfg_ready = !out_valid && !in_valid;
    end

    if (cfg_fire) begin
      if (last_beat && cfg_last) begin
        state_d = RUN;
        addr_d  = '0;
        nrn_d   = '0;
        err_d   = 1'b0;
      end else if (last_beat || cfg_last) begin
        // Framing error: the beat is already written, but the image is dropped.
        state_d = EMPTY;
        addr_d  = '0;
        nrn_d   = '0;
        err_d   = 1'b1;
      end else begin
        state_d = LOAD;
        addr_d  = addr_q + 1'b1;
        if (&addr_q) begin
          nrn_d = nrn_q + 1'b1;
        end
      end
    end
  end

  assign cfg_err = err_q;

  // Single output register stage: load on accept, clear once consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_data  <= lut_rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lut_neuron_layer.sv
// Self-checking bench for lut_neuron_layer with a 2-neuron, 3-bit-address,
// 2-bit-output configuration. The reference keeps the tables as plain arrays
// indexed by beat number and models the output stage as a single held word.
module tb_lut_neuron_layer;

  localparam int NN    = 2;
  localparam int IB    = 3;
  localparam int OB    = 2;
  localparam int DEPTH = 8;
  localparam int TOTAL = NN * DEPTH;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [OB-1:0]    cfg_data = '0;
  logic             cfg_last = 1'b0;
  logic             cfg_err;
  logic             loaded;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [NN*IB-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [NN*OB-1:0] out_data;

  int checks = 0;
  int failures = 0;

  // Reference state
  logic [OB-1:0]    tbl [NN][DEPTH];
  int               k;
  bit               m_loaded, m_err, m_valid;
  logic [NN*OB-1:0] m_data;

  lut_neuron_layer #(.NUM_NEURONS(NN), .IN_BITS(IB), .OUT_BITS(OB)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .cfg_last(cfg_last), .cfg_err(cfg_err), .loaded(loaded),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NN*OB-1:0] ref_out(input logic [NN*IB-1:0] a);
    logic [NN*OB-1:0] r;
    r = '0;
    for (int n = 0; n < NN; n++) r[n*OB +: OB] = tbl[n][a[n*IB +: IB]];
    return r;
  endfunction

  // Reset for one edge; optionally with a config beat presented alongside.
  task automatic do_reset(input bit with_beat);
    rst_n = 1'b0;
    in_valid = 1'b0;
    cfg_valid = with_beat;
    cfg_data = 2'd3;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cfg_valid = 1'b0;
    k = 0; m_loaded = 0; m_err = 0; m_valid = 0; m_data = '0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
  endtask

  // One inference cycle: present input / out_ready, then check the result.
  task automatic step(input bit iv, input logic [NN*IB-1:0] id, input bit ordy);
    bit exp_rdy;
    in_valid = iv; in_data = id; out_ready = ordy; cfg_valid = 1'b0;
    #1;
    exp_rdy = m_loaded && (!m_valid || ordy);
    chk("in_ready", in_ready, exp_rdy);
    if (iv && exp_rdy) begin
      m_data = ref_out(id);
      m_valid = 1;
    end else if (ordy) begin
      m_valid = 0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("out_valid", out_valid, m_valid);
    if (m_valid) chk("out_data", out_data, m_data);
  endtask

  // One config beat with the pipeline drained; checks status after the edge.
  task automatic beat(input logic [OB-1:0] d, input bit last);
    bit exp_cr;
    in_valid = 1'b0; out_ready = 1'b1;
    cfg_valid = 1'b1; cfg_data = d; cfg_last = last;
    #1;
    exp_cr = !m_loaded || !m_valid;
    chk("cfg_ready", cfg_ready, exp_cr);
    if (exp_cr) begin
      tbl[k / DEPTH][k % DEPTH] = d;
      if (k == TOTAL - 1 && last) begin
        m_loaded = 1; m_err = 0; k = 0;
      end else if (k == TOTAL - 1 || last) begin
        m_loaded = 0; m_err = 1; k = 0;
      end else begin
        m_loaded = 0; k++;
      end
    end
    m_valid = 0;
    @(posedge clk); #1;
    cfg_valid = 1'b0; cfg_last = 1'b0;
    chk("loaded", loaded, m_loaded);
    chk("cfg_err", cfg_err, m_err);
    chk("in_ready_cfg", in_ready, m_loaded);
  endtask

  // kind 0: (a+n)%4, kind 1: 3-a%4, kind 2: random. last_at<0 means no cfg_last.
  task automatic load_img(input int kind, input int nbeats, input int last_at);
    int n, a;
    logic [OB-1:0] d;
    for (int b = 0; b < nbeats; b++) begin
      n = b / DEPTH; a = b % DEPTH;
      if (kind == 0)      d = OB'((a + n) % 4);
      else if (kind == 1) d = OB'(3 - a % 4);
      else                d = OB'($urandom);
      beat(d, b == last_at);
    end
  endtask

  task automatic rand_run(input int cycles);
    for (int c = 0; c < cycles; c++)
      step(1'($urandom_range(0, 1)), 6'($urandom), $urandom_range(0, 3) != 0);
    step(1'b0, '0, 1'b1);
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset(1'b0);

    // 1: initial load
    load_img(0, TOTAL, TOTAL - 1);
    chk("t1_loaded", loaded, 1);
    chk("t1_cfg_err", cfg_err, 0);

    // 2: back-to-back inference
    step(1'b1, 6'b101_010, 1'b1);
    chk("t2_word0", out_data, 4'b10_10);
    step(1'b1, 6'b111_000, 1'b1);
    chk("t2_word1", out_data, 4'b00_00);
    step(1'b0, '0, 1'b1);

    // 3: stall with a result pending
    step(1'b1, 6'b001_011, 1'b0);
    step(1'b1, 6'b100_110, 1'b0);
    step(1'b1, 6'b100_110, 1'b0);
    chk("t3_hold", out_data, 4'b10_11);
    step(1'b1, 6'b100_110, 1'b1);
    chk("t3_second", out_data, 4'b01_10);
    step(1'b0, '0, 1'b1);

    // input wins over config in RUN
    in_valid = 1'b1; in_data = 6'b010_101; cfg_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("both_cfg_ready", cfg_ready, 0);
    step(1'b1, 6'b010_101, 1'b1);
    step(1'b0, '0, 1'b1);

    rand_run(200);

    // 4: early cfg_last, then full reload
    load_img(2, 7, 6);
    chk("t4_err", cfg_err, 1);
    chk("t4_loaded", loaded, 0);
    chk("t4_in_ready", in_ready, 0);
    load_img(0, TOTAL, TOTAL - 1);
    chk("t4_reload_err", cfg_err, 0);
    chk("t4_reload_loaded", loaded, 1);

    // 5: reload from RUN
    step(1'b0, '0, 1'b1);
    load_img(1, TOTAL, TOTAL - 1);
    step(1'b1, 6'b001_001, 1'b1);
    chk("t5_word", out_data, 4'b10_10);
    step(1'b0, '0, 1'b1);

    // reset with a held output
    step(1'b1, 6'($urandom), 1'b0);
    do_reset(1'b0);

    // 4c: full image without cfg_last
    load_img(0, TOTAL, -1);
    chk("t4c_err", cfg_err, 1);

    // 6: reset on beat 9 of a load
    load_img(2, 9, -1);
    do_reset(1'b1);
    load_img(2, TOTAL, TOTAL - 1);
    rand_run(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
